// File: rtl/bcd_stream_encoder_pkg.sv
// bcd_pkg: shared digit width, encoder state type and add-3 digit correction
package bcd_pkg;
  localparam int DIGIT_W = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] d);
    return d >= 4'd5 ? d + 4'd3 : d;
  endfunction
endpackage

// File: rtl/bcd_stream_encoder_if.sv
// bcd_stream_encoder_if: value-in / BCD-out handshake bundle for the stream encoder
interface bcd_stream_encoder_if import bcd_pkg::*; #(
  parameter int BINARY_LENGTH = 128,
  parameter int DECIMAL_LENGTH = 39
);
  logic in_valid;
  logic in_ready;
  logic [BINARY_LENGTH-1:0] binary_data;
  logic out_valid;
  logic out_ready;
  logic [DECIMAL_LENGTH*DIGIT_W-1:0] BCD_data;
  logic sign;
  logic overflow;
  logic [$clog2(DECIMAL_LENGTH+1)-1:0] digit_count;
  modport master(
    output in_valid, binary_data, out_ready,
    input in_ready, out_valid, BCD_data, sign, overflow, digit_count
  );
  modport slave(
    input in_valid, binary_data, out_ready,
    output in_ready, out_valid, BCD_data, sign, overflow, digit_count
  );
endinterface

// File: rtl/bcd_stream_encoder_digit_cell.sv
// bcd_digit_cell: one double-dabble digit; add-3 correct, shift in carry, pass MSB upward
module bcd_digit_cell import bcd_pkg::*; (
  input  logic [DIGIT_W-1:0] digit,
  input  logic               carry_in,
  output logic [DIGIT_W-1:0] digit_next,
  output logic               carry_out
);
  logic [DIGIT_W-1:0] adj;
  assign adj = add3(digit);
  assign digit_next = {adj[DIGIT_W-2:0], carry_in};
  assign carry_out = adj[DIGIT_W-1];
endmodule

// File: rtl/bcd_stream_encoder.sv
// bcd_stream_encoder: sequential signed/unsigned binary-to-BCD converter with overflow and digit count
module bcd_stream_encoder import bcd_pkg::*; #(
  parameter int BINARY_LENGTH = 128,
  parameter int DECIMAL_LENGTH = 39,
  parameter int SIGNED = 0
) (
  input logic CLK,
  input logic RST_N,
  bcd_stream_encoder_if.slave bus
);
  localparam int CW = $clog2(BINARY_LENGTH + 1);
  localparam int BW = DECIMAL_LENGTH * DIGIT_W;
  localparam int DW = $clog2(DECIMAL_LENGTH + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BINARY_LENGTH-1:0] mag_q, mag_d;
  logic [BW-1:0] bcd_q, bcd_d, bcd_sh;
  logic sign_q, sign_d, ovf_q, ovf_d, neg;
  logic [DECIMAL_LENGTH:0] carry;
  logic [DW-1:0] dcnt;
  assign carry[0] = mag_q[BINARY_LENGTH-1];
  for (genvar i = 0; i < DECIMAL_LENGTH; i++) begin : g_cell
    bcd_digit_cell u_cell (
      .digit(bcd_q[i*DIGIT_W +: DIGIT_W]),
      .carry_in(carry[i]),
      .digit_next(bcd_sh[i*DIGIT_W +: DIGIT_W]),
      .carry_out(carry[i+1])
    );
  end
  assign neg = (SIGNED != 0) && bus.binary_data[BINARY_LENGTH-1];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mag_d = mag_q;
    bcd_d = bcd_q;
    sign_d = sign_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = SHIFT;
        mag_d = neg ? -bus.binary_data : bus.binary_data;
        sign_d = neg;
        bcd_d = '0;
        ovf_d = 1'b0;
        cnt_d = CW'(BINARY_LENGTH);
      end
      SHIFT: begin
        mag_d = mag_q << 1;
        bcd_d = bcd_sh;
        ovf_d = ovf_q | carry[DECIMAL_LENGTH];
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? DONE : SHIFT;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mag_q <= '0;
      bcd_q <= '0;
      sign_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mag_q <= mag_d;
      bcd_q <= bcd_d;
      sign_q <= sign_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    dcnt = DW'(1);
    for (int i = 0; i < DECIMAL_LENGTH; i++)
      if (bcd_q[i*DIGIT_W +: DIGIT_W] != '0) dcnt = DW'(i + 1);
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.BCD_data = bcd_q;
  assign bus.sign = sign_q;
  assign bus.overflow = ovf_q;
  assign bus.digit_count = dcnt;
endmodule

// File: tb/tb_bcd_stream_encoder.sv
// tb_bcd_stream_encoder: random and directed checks of three encoder configurations against a decimal model
module tb_bcd_stream_encoder;
  logic CLK, RST_N;
  int checks = 0;
  int errs = 0;
  bcd_stream_encoder_if #(.BINARY_LENGTH(128), .DECIMAL_LENGTH(39)) b_if ();
  bcd_stream_encoder_if #(.BINARY_LENGTH(8), .DECIMAL_LENGTH(2)) s_if ();
  bcd_stream_encoder_if #(.BINARY_LENGTH(8), .DECIMAL_LENGTH(3)) g_if ();
  bcd_stream_encoder #(.BINARY_LENGTH(128), .DECIMAL_LENGTH(39), .SIGNED(0)) u_big (.CLK(CLK), .RST_N(RST_N), .bus(b_if));
  bcd_stream_encoder #(.BINARY_LENGTH(8), .DECIMAL_LENGTH(2), .SIGNED(0)) u_sml (.CLK(CLK), .RST_N(RST_N), .bus(s_if));
  bcd_stream_encoder #(.BINARY_LENGTH(8), .DECIMAL_LENGTH(3), .SIGNED(1)) u_sgn (.CLK(CLK), .RST_N(RST_N), .bus(g_if));
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void bcd_ref(input logic [127:0] v, input int d, output logic [159:0] bcd, output logic ovf, output int dc);
    logic [127:0] r;
    r = v;
    bcd = '0;
    dc = 1;
    for (int i = 0; i < d; i++) begin
      bcd[i*4 +: 4] = 4'(r % 10);
      if (r % 10 != 0) dc = i + 1;
      r = r / 10;
    end
    ovf = r != 0;
  endfunction
  task automatic big_send(input logic [127:0] v);
    int k = 0;
    while (!b_if.in_ready && k < 400) begin
      @(negedge CLK);
      k++;
    end
    chk("send_rdy", 160'(b_if.in_ready), 160'(1));
    b_if.in_valid = 1'b1;
    b_if.binary_data = v;
    @(negedge CLK);
    b_if.in_valid = 1'b0;
    b_if.binary_data = {$urandom, $urandom, $urandom, $urandom};
  endtask
  task automatic big_recv(input logic [127:0] v, input int hold, input logic [127:0] nxt);
    int k = 0;
    int edc;
    logic [159:0] eb;
    logic eo;
    b_if.out_ready = hold == 0;
    while (!b_if.out_valid && k < 400) begin
      @(negedge CLK);
      k++;
    end
    bcd_ref(v, 39, eb, eo, edc);
    chk("latency", 160'(k), 160'(128));
    chk("bcd", 160'(b_if.BCD_data), eb);
    chk("ovf", 160'(b_if.overflow), 160'(eo));
    chk("dcnt", 160'(b_if.digit_count), 160'(edc));
    chk("sign", 160'(b_if.sign), 160'(0));
    chk("rdy_done", 160'(b_if.in_ready), 160'(0));
    if (hold > 0) begin
      b_if.in_valid = 1'b1;
      b_if.binary_data = nxt;
      repeat (hold) @(negedge CLK);
      chk("hold_bcd", 160'(b_if.BCD_data), eb);
      chk("hold_valid", 160'(b_if.out_valid), 160'(1));
      chk("hold_rdy", 160'(b_if.in_ready), 160'(0));
      b_if.out_ready = 1'b1;
      @(negedge CLK);
      chk("rel_rdy", 160'(b_if.in_ready), 160'(1));
      @(negedge CLK);
      b_if.in_valid = 1'b0;
    end else begin
      @(negedge CLK);
      chk("reaccept", 160'(b_if.in_ready), 160'(1));
    end
  endtask
  task automatic sml_xfer(input logic [7:0] v);
    int k = 0;
    int edc;
    logic [159:0] eb;
    logic eo;
    s_if.in_valid = 1'b1;
    s_if.binary_data = v;
    @(negedge CLK);
    s_if.in_valid = 1'b0;
    s_if.binary_data = 8'($urandom);
    while (!s_if.out_valid && k < 50) begin
      @(negedge CLK);
      k++;
    end
    bcd_ref({120'b0, v}, 2, eb, eo, edc);
    chk("s_latency", 160'(k), 160'(8));
    chk("s_bcd", 160'(s_if.BCD_data), eb);
    chk("s_ovf", 160'(s_if.overflow), 160'(eo));
    chk("s_dcnt", 160'(s_if.digit_count), 160'(edc));
    @(negedge CLK);
  endtask
  task automatic sgn_xfer(input logic [7:0] v);
    int k = 0;
    int edc, sv;
    logic [159:0] eb;
    logic eo;
    sv = int'($signed(v));
    g_if.in_valid = 1'b1;
    g_if.binary_data = v;
    @(negedge CLK);
    g_if.in_valid = 1'b0;
    g_if.binary_data = 8'($urandom);
    while (!g_if.out_valid && k < 50) begin
      @(negedge CLK);
      k++;
    end
    bcd_ref(128'(sv < 0 ? -sv : sv), 3, eb, eo, edc);
    chk("g_latency", 160'(k), 160'(8));
    chk("g_bcd", 160'(g_if.BCD_data), eb);
    chk("g_sign", 160'(g_if.sign), 160'(sv < 0));
    chk("g_ovf", 160'(g_if.overflow), 160'(eo));
    chk("g_dcnt", 160'(g_if.digit_count), 160'(edc));
    @(negedge CLK);
  endtask
  initial begin
    logic [127:0] v, w;
    RST_N = 1'b0;
    b_if.in_valid = 1'b0; b_if.binary_data = '0; b_if.out_ready = 1'b1;
    s_if.in_valid = 1'b0; s_if.binary_data = '0; s_if.out_ready = 1'b1;
    g_if.in_valid = 1'b0; g_if.binary_data = '0; g_if.out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    chk("rst_rdy", 160'(b_if.in_ready), 160'(1));
    chk("rst_valid", 160'(b_if.out_valid), 160'(0));
    chk("rst_bcd", 160'(b_if.BCD_data), 160'(0));
    chk("rst_sign", 160'(b_if.sign), 160'(0));
    chk("rst_ovf", 160'(b_if.overflow), 160'(0));
    chk("rst_dcnt", 160'(b_if.digit_count), 160'(1));
    big_send(128'd54);
    big_recv(128'd54, 0, '0);
    chk("bcd_54", 160'(b_if.BCD_data), 160'h054);
    big_send('1);
    big_recv('1, 0, '0);
    for (int n = 0; n < 6; n++) begin
      v = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 127);
      big_send(v);
      big_recv(v, 0, '0);
    end
    v = {$urandom, $urandom, $urandom, $urandom};
    w = 128'($urandom);
    big_send(v);
    big_recv(v, 10, w);
    big_recv(w, 0, '0);
    big_send({$urandom, $urandom, $urandom, $urandom});
    repeat (4) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("mid_rst_valid", 160'(b_if.out_valid), 160'(0));
    chk("mid_rst_rdy", 160'(b_if.in_ready), 160'(1));
    chk("mid_rst_bcd", 160'(b_if.BCD_data), 160'(0));
    big_send(128'd999);
    big_recv(128'd999, 0, '0);
    chk("bcd_999", 160'(b_if.BCD_data), 160'h999);
    sml_xfer(8'd255);
    chk("s_255", 160'(s_if.BCD_data), 160'h55);
    sml_xfer(8'd0);
    for (int n = 0; n < 6; n++) sml_xfer(8'($urandom));
    sgn_xfer(8'h80);
    sgn_xfer(8'hF6);
    sgn_xfer(8'h7F);
    for (int n = 0; n < 6; n++) sgn_xfer(8'($urandom));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bcd_stream_encoder.md
# bcd_stream_encoder

Sequential, parametrised binary-to-BCD converter (shift-add-3 / double dabble) with valid/ready handshakes on both sides. It adds signed input, an overflow flag for undersized digit counts, and a significant-digit count for display blanking. It sits between the value source and the digit display/transmit logic, and feeds square-generator readouts.

## Interface
- BINARY_LENGTH, 128: input word width in bits (≥2).
- DECIMAL_LENGTH, 39: number of 4-bit BCD output digits (≥1).
- SIGNED, 0: 1 = binary_data is two's complement; 0 = unsigned.
- CLK  in  1  single clock; all state updates on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- in_valid  in  1  binary_data is valid.
- in_ready  out  1  block accepts a word; high only in IDLE.
- binary_data  in  BINARY_LENGTH  value to convert; sampled on the accept edge only.
- out_valid  out  1  result outputs are valid and held.
- out_ready  in  1  consumer accepts the result.
- BCD_data  out  DECIMAL_LENGTH*4  packed BCD result; digit 0 is bits [3:0].
- sign  out  1  1 = negative input (always 0 when SIGNED=0).
- overflow  out  1  magnitude ≥ 10^DECIMAL_LENGTH; BCD_data then holds magnitude mod 10^DECIMAL_LENGTH.
- digit_count  out  $clog2(DECIMAL_LENGTH+1)  index of the most significant non-zero digit + 1; 1 for zero.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: capture the magnitude into the shift register (negated if SIGNED and MSB=1), capture sign, clear BCD accumulator and overflow, load bit counter with BINARY_LENGTH, go to SHIFT.
- SHIFT: each cycle, every digit ≥5 gets +3, then {BCD, magnitude} shifts left by 1. The bit leaving the top digit ORs into overflow. Counter decrements; on the cycle it reaches 1, go to DONE.
- DONE: out_valid=1, and BCD_data/sign/overflow/digit_count stay constant. On out_ready go to IDLE.
- No overlap: in_ready=0 in SHIFT and DONE; in_valid is ignored there and binary_data is not sampled.
- Signed most-negative value (e.g. 0x80 for 8 bits) gives magnitude 2^(BINARY_LENGTH-1), converted correctly with no overflow from negation.
- digit_count is combinational from the held BCD register. It is defined only while out_valid=1 and reflects the truncated value when overflow=1.
- Reset (RST_N low at an edge), from any state including mid-SHIFT: next state IDLE. out_valid, BCD_data, sign, overflow, counter and shift register all go to 0, and the partial conversion is discarded. Inputs are ignored while RST_N is low.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, BCD_data=0, sign=0, overflow=0, digit_count=1.
- Latency: out_valid rises exactly BINARY_LENGTH cycles after the accept edge.
- Throughput: one word per BINARY_LENGTH+2 cycles with out_ready held high (accept edge, BINARY_LENGTH shifts, release edge).
- Earliest re-accept: in_ready is high in the cycle after the out_valid&&out_ready edge.
- Back-pressure is unbounded: DONE holds indefinitely with outputs stable.

## Structure
- Package bcd_pkg: DIGIT_W=4, the state enum (IDLE/SHIFT/DONE), and an add3 correction function shared with the existing encoder.
- Sub-module bcd_digit_cell, generated DECIMAL_LENGTH times. Each cell applies add-3, shifts in a carry from the digit below, and outputs its MSB as carry-out. The top cell's carry-out feeds overflow.
- The top-level bcd_stream_encoder holds the FSM, bit counter, magnitude register, sign/overflow flags and the digit_count priority encoder.

## Test plan
- Defaults, binary_data=54, out_ready=1: out_valid rises 128 cycles after accept; BCD_data=0x…054; digit_count=2; sign=0; overflow=0.
- Defaults, binary_data=2^128-1: BCD_data = 340282366920938463463374607431768211455 (all 39 digits); digit_count=39; overflow=0.
- BINARY_LENGTH=8, DECIMAL_LENGTH=2, binary_data=255: BCD_data=0x55; overflow=1. Then binary_data=0: BCD_data=0x00, digit_count=1, overflow=0.
- BINARY_LENGTH=8, SIGNED=1, inputs 0x80 then 0xF6: first gives sign=1, BCD=128, digit_count=3; second gives sign=1, BCD=10.
- Back-pressure: out_ready=0 for 10 cycles after out_valid while in_valid=1 with new data. Outputs stay frozen, in_ready stays 0, and the new word is accepted only after release.
- Reset mid-conversion: RST_N low for 1 cycle on the 5th SHIFT cycle. Next cycle out_valid=0, in_ready=1, BCD_data=0. A following conversion of 999 gives BCD=0x999 with the normal latency.
